// File: rtl/conversor_display_pkg.sv
// Shared types and constants for the binary-to-7-segment display converter.
package conversor_display_pkg;

  localparam int unsigned W_VALOR = 32;
  localparam int unsigned W_MAG   = 17;
  localparam int unsigned W_BCD   = 20;
  localparam int unsigned W_CNT   = 5;
  localparam int unsigned N_DIG   = 5;
  localparam int unsigned N_ITER  = 17;
  localparam int unsigned MAX_POS = 99999;
  localparam int unsigned MAX_NEG = 9999;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  // Segments a..g, active-low
  typedef logic [0:6] seg_t;

  localparam seg_t BLANK    = 7'b1111111;
  localparam seg_t DASH     = 7'b1111110;
  localparam seg_t LETTER_E = 7'b0110000;
  localparam seg_t DIG0     = 7'b0000001;
  localparam seg_t DIG1     = 7'b1001111;
  localparam seg_t DIG2     = 7'b0010010;
  localparam seg_t DIG3     = 7'b0000110;
  localparam seg_t DIG4     = 7'b1001100;
  localparam seg_t DIG5     = 7'b0100100;
  localparam seg_t DIG6     = 7'b0100000;
  localparam seg_t DIG7     = 7'b0001111;
  localparam seg_t DIG8     = 7'b0000000;
  localparam seg_t DIG9     = 7'b0000100;

  function automatic seg_t digito_para_seg(input logic [3:0] d);
    case (d)
      4'd0:    return DIG0;
      4'd1:    return DIG1;
      4'd2:    return DIG2;
      4'd3:    return DIG3;
      4'd4:    return DIG4;
      4'd5:    return DIG5;
      4'd6:    return DIG6;
      4'd7:    return DIG7;
      4'd8:    return DIG8;
      4'd9:    return DIG9;
      default: return BLANK;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module decodificador_7seg
  import conversor_display_pkg::*;
(
  input  logic [3:0] digito,
  input  logic       apagado,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = BLANK;
    if (!apagado) seg_c = digito_para_seg(digito);
  end

endmodule

// File: rtl/conversor_display.sv
// Converts a signed 32-bit value to five 7-segment digits via serial double-dabble.
module conversor_display
  import conversor_display_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [W_VALOR-1:0] valor,
  input  logic               carrega,
  output logic               ocupado,
  output logic               pronto,
  output seg_t               disp1,
  output seg_t               disp2,
  output seg_t               disp3,
  output seg_t               disp4,
  output seg_t               disp5
);

  estado_t            estado_q, estado_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic [W_MAG-1:0]   mag_q, mag_d;
  logic [W_BCD-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               ocupado_q, ocupado_d;
  logic               pronto_q, pronto_d;
  seg_t               disp_q [N_DIG];
  seg_t               disp_d [N_DIG];

  logic [W_VALOR-1:0] abs_c;
  logic               neg_c;
  logic               ovf_c;
  logic [W_BCD-1:0]   bcd_adj_c;
  logic [N_DIG-1:0]   apagado_c;
  seg_t               seg_c   [N_DIG];
  seg_t               final_c [N_DIG];

  // Magnitude and range check of the incoming value (-2^31 stays out of range)
  always_comb begin
    neg_c = valor[W_VALOR-1];
    abs_c = neg_c ? (~valor + W_VALOR'(1)) : valor;
    ovf_c = neg_c ? (abs_c > W_VALOR'(MAX_NEG)) : (valor > W_VALOR'(MAX_POS));
  end

  // Add-3 correction applied before each shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Leading zeros blank from the top down; units digit always shown
  always_comb begin
    apagado_c = '0;
    apagado_c[N_DIG-1] = (bcd_q[4*(N_DIG-1) +: 4] == 4'd0);
    for (int i = int'(N_DIG) - 2; i >= 1; i--) begin
      apagado_c[i] = apagado_c[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
  end

  for (genvar g = 0; g < int'(N_DIG); g++) begin : g_dec
    decodificador_7seg u_dec (
      .digito  (bcd_q[4*g +: 4]),
      .apagado (apagado_c[g]),
      .seg_c   (seg_c[g])
    );
  end

  always_comb begin
    for (int i = 0; i < int'(N_DIG); i++) begin
      final_c[i] = seg_c[i];
      if (neg_q && (i == int'(N_DIG) - 1)) final_c[i] = DASH;
      if (ovf_q) final_c[i] = LETTER_E;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    pronto_d = 1'b0;
    for (int i = 0; i < int'(N_DIG); i++) disp_d[i] = disp_q[i];

    case (estado_q)
      OCIOSO: begin
        if (carrega) begin
          neg_d    = neg_c;
          ovf_d    = ovf_c;
          mag_d    = abs_c[W_MAG-1:0];
          cnt_d    = W_CNT'(N_ITER);
          bcd_d    = '0;
          estado_d = CONVERTE;
        end
      end
      CONVERTE: begin
        bcd_d = {bcd_adj_c[W_BCD-2:0], mag_q[W_MAG-1]};
        mag_d = {mag_q[W_MAG-2:0], 1'b0};
        cnt_d = cnt_q - W_CNT'(1);
        if (cnt_q == W_CNT'(1)) estado_d = ATUALIZA;
      end
      ATUALIZA: begin
        for (int i = 0; i < int'(N_DIG); i++) disp_d[i] = final_c[i];
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      mag_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      for (int i = 0; i < int'(N_DIG); i++) disp_q[i] <= BLANK;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      for (int i = 0; i < int'(N_DIG); i++) disp_q[i] <= disp_d[i];
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign disp1   = disp_q[0];
  assign disp2   = disp_q[1];
  assign disp3   = disp_q[2];
  assign disp4   = disp_q[3];
  assign disp5   = disp_q[4];

endmodule

// File: tb/tb_conversor_display.sv
// Scoreboard bench for conversor_display: decimal reference model, queued expectations.
module tb_conversor_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        carrega = 1'b0;
  logic [31:0] valor = '0;
  logic        ocupado, pronto;
  logic [0:6]  disp1, disp2, disp3, disp4, disp5;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_DASH  = 7'b1111110;
  localparam logic [6:0] S_E     = 7'b0110000;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam int LATENCIA = 18;

  conversor_display dut (
    .clk     (clk),
    .rst     (rst),
    .valor   (valor),
    .carrega (carrega),
    .ocupado (ocupado),
    .pronto  (pronto),
    .disp1   (disp1),
    .disp2   (disp2),
    .disp3   (disp3),
    .disp4   (disp4),
    .disp5   (disp5)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  // Expected display image {disp5..disp1} from decimal arithmetic
  function automatic logic [34:0] modelo(input logic [31:0] v);
    longint    sv;
    longint    mag;
    longint    p;
    logic [6:0] d [5];
    sv = longint'($signed(v));
    if ((sv >= 0 && sv > 99999) || (sv < 0 && -sv > 9999)) return {5{S_E}};
    mag = (sv < 0) ? -sv : sv;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || mag >= p) d[k] = SEG_TAB[int'((mag / p) % 10)];
      else d[k] = S_BLANK;
      p = p * 10;
    end
    if (sv < 0) d[4] = S_DASH;
    return {d[4], d[3], d[2], d[1], d[0]};
  endfunction

  logic [34:0] exp_q [$];
  int          cyc_q [$];
  int          edge_n = 0;
  int          next_free = 0;
  int          last_acc = -100;
  logic [34:0] shown = {5{S_BLANK}};

  // Reference model: accepts a load only when its own busy window has passed
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cyc_q.delete();
      next_free = 0;
      last_acc  = -100;
      shown     = {5{S_BLANK}};
    end else begin
      edge_n++;
      if (carrega && edge_n >= next_free) begin
        exp_q.push_back(modelo(valor));
        cyc_q.push_back(edge_n + LATENCIA);
        next_free = edge_n + LATENCIA + 1;
        last_acc  = edge_n;
      end
    end
  end

  // Monitor: pops on pronto, checks held displays and busy flag every cycle
  always @(negedge clk) begin
    logic [34:0] disps;
    logic [34:0] e;
    disps = {disp5, disp4, disp3, disp2, disp1};
    if (!rst) begin
      chk("reset_disp", disps, {5{S_BLANK}});
      chk("reset_pronto", pronto, 1'b0);
      chk("reset_ocupado", ocupado, 1'b0);
    end else begin
      if (cyc_q.size() > 0 && edge_n > cyc_q[0]) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_pronto: edge %0d expected pronto at edge %0d", edge_n, cyc_q[0]);
        void'(cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (pronto) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pronto: pronto=1 at edge %0d expected 0", edge_n);
        end else begin
          chk("latency", 64'(edge_n), 64'(cyc_q.pop_front()));
          e = exp_q.pop_front();
          chk("displays", disps, e);
          shown = e;
        end
      end
      chk("hold", disps, shown);
      chk("ocupado", ocupado, (edge_n >= last_acc) && (edge_n < last_acc + LATENCIA));
    end
  end

  task automatic load(input logic [31:0] v);
    @(negedge clk);
    valor   = v;
    carrega = 1'b1;
    @(negedge clk);
    carrega = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] bordas [10];
    bordas = '{32'd99999, 32'd100000, 32'hFFFFD8F1, 32'hFFFFD8F0, 32'd0,
               32'hFFFFFFFF, 32'd10, 32'h7FFFFFFF, 32'h80000000, 32'd131071};
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 99999));
      1: return 32'(-int'($urandom_range(0, 9999)));
      2: return bordas[$urandom_range(0, 9)];
      3: return $urandom;
      4: return 32'($urandom_range(0, 999));
      default: return 32'(-int'($urandom_range(0, 99)));
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    load(32'd12345);      idle(20);
    load(32'd0);          idle(20);
    load(32'hFFFFFFD6);   idle(20);
    load(32'd100000);     idle(20);
    load(32'hFFFFD8F0);   idle(20);
    load(32'h80000000);   idle(20);

    // Second load lands mid-conversion and must be dropped
    load(32'd99999);      idle(3);
    load(32'd7);          idle(20);
    load(32'd7);          idle(20);

    // Reset around edge 10 of a conversion
    load(32'd54321);      idle(8);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_disp", {disp5, disp4, disp3, disp2, disp1}, {5{S_BLANK}});
    chk("abort_pronto", pronto, 1'b0);
    idle(3);
    @(negedge clk);
    #1 rst = 1'b1;
    load(32'd8);          idle(20);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      valor   = rand_val();
      carrega = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    carrega = 1'b0;
    idle(25);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conversor_display.md
CONVERSOR_DISPLAY -- requirements
Module: conversor_display

Interface
REQ-001 SHALL have port clk  input  1  single system clock (the divided processor clock); all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port valor  input  32  two's-complement value from the register-bank output path.
REQ-004 SHALL have port carrega  input  1  load strobe; sampled only in state OCIOSO.
REQ-005 SHALL have port ocupado  output  1  high while a conversion is in progress (states CONVERTE, ATUALIZA).
REQ-006 SHALL have port pronto  output  1  one-cycle pulse when the displays update.
REQ-007 SHALL have ports disp1..disp5  output  7 each, index [0:6] = segments a..g, active-low; disp1 = units, disp5 = most significant.

Function
REQ-008 SHALL implement FSM OCIOSO -> CONVERTE -> ATUALIZA -> OCIOSO.
REQ-009 In OCIOSO with carrega=1 SHALL capture sign, magnitude |valor| (17 LSBs), and the overflow flag, load iteration counter = 17, clear the 20-bit BCD accumulator, and go to CONVERTE.
REQ-010 Overflow SHALL be set when valor >= 0 and valor > 99999, or when valor < 0 and |valor| > 9999 (includes -2^31).
REQ-011 In CONVERTE SHALL perform one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift left one bit with the next magnitude MSB; decrement the counter; go to ATUALIZA after the 17th iteration.
REQ-012 In ATUALIZA SHALL load all five display registers simultaneously, assert pronto for that one cycle, and return to OCIOSO.
REQ-013 Latency SHALL be fixed: displays change on the 18th rising edge after the edge that samples carrega, regardless of value or overflow.
REQ-014 carrega SHALL be ignored while ocupado=1; no queuing.
REQ-015 Display outputs SHALL hold their last value between updates.
REQ-016 Non-negative, no overflow: SHALL show five digits with leading zeros blanked (1111111); disp1 SHALL always show a digit, so 0 shows '0' on disp1 only.
REQ-017 Negative, no overflow: disp5 SHALL show '-' (1111110); disp4..disp1 SHALL show the magnitude with the same leading-zero blanking.
REQ-018 Overflow: all five displays SHALL show 'E' (0110000).
REQ-019 Digit encodings SHALL be 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.

Reset
REQ-020 On rst=0, asynchronously: state OCIOSO, ocupado=0, pronto=0, counter=0, accumulator=0, disp1..disp5=1111111 (blank).
REQ-021 Reset asserted mid-conversion SHALL abort it; displays SHALL be blank, and no pronto pulse SHALL occur after release.
REQ-022 The first carrega sampled after reset release SHALL be honoured normally.

Structure
REQ-023 A shared package SHALL hold: state encoding (OCIOSO, CONVERTE, ATUALIZA), N_ITER=17, MAX_POS=99999, MAX_NEG=9999, and the segment constants BLANK, DASH, LETTER_E, DIG0..DIG9.
REQ-024 A combinational sub-module decodificador_7seg SHALL map a 4-bit BCD digit plus a blank flag to 7 segments and SHALL be instantiated five times; the sign and overflow overrides SHALL reside in the parent module.

Verification
REQ-025 valor=12345, carrega 1 cycle -> after 18 edges disp5..disp1 = 1,2,3,4,5; pronto high exactly 1 cycle; ocupado high for 18 cycles.
REQ-026 valor=0 -> disp1='0'; disp2..disp5 blank.
REQ-027 valor=-42 (0xFFFFFFD6) -> disp5='-', disp4/disp3 blank, disp2='4', disp1='2'.
REQ-028 valor=100000, then valor=-10000, then valor=0x80000000 -> all displays 'E' each time, each with 18-cycle latency.
REQ-029 valor=99999 loaded; a second carrega with valor=7 at edge 5 of the conversion -> it is ignored and the result is 9,9,9,9,9; a third carrega with 7 after pronto -> disp1='7', others blank.
REQ-030 rst=0 at edge 10 of a conversion of 54321 -> outputs blank immediately, no pronto; after release, load 8 -> disp1='8'.
